instr_encode_loader: RTL
========================

# instr_encode_loader

Sequential RV32I instruction encoder and instruction-memory loader: the encode-side counterpart of the main decoder. It accepts field-level instruction descriptions over a valid/ready handshake and packs each into a 32-bit word, including I/S/B immediate scattering. It then writes the words to consecutive instruction-memory addresses, so the single-cycle core's program memory is filled by testbenches and the boot path. It handles only the opcode classes the core decodes: load, store, R-type, I-type ALU and branch.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width (capacity 2^ADDR_W words)
- BASE_ADDR, 0, first word address written in a session

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  open a load session (honored only in IDLE)
- finish  in  1  close the session (honored only in ACCEPT with in_valid low)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept fields this cycle
- in_class  in  3  0 load, 1 store, 2 R-type, 3 I-type ALU, 4 branch, 5-7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  funct7 bit 5 (sub/sra/srai)
- in_imm  in  13  signed immediate (bits 11:0 used for load/store/I; 12:1 for branch)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- busy  out  1  session open (ACCEPT, WRITE or DONE)
- done  out  1  one-cycle pulse at session close
- error  out  1  sticky: illegal class, misaligned branch or overflow attempt

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE -> ACCEPT on start. Load address with BASE_ADDR, clear count and error.
- ACCEPT: in_ready = 1 unless count == 2^ADDR_W (full).
- On a handshake (in_valid & in_ready) with a legal class:
  - Register the encoded word in imem_wdata.
  - Go to WRITE.
- On a handshake with an illegal class, or a branch with in_imm[0]=1:
  - Set error.
  - Write nothing and do not advance the address.
  - Stay in ACCEPT.
- ACCEPT with in_valid high while full: set error and do not accept.
- WRITE: imem_we = 1 for exactly one cycle. Address advances by 1 (modulo 2^ADDR_W), count increments, then back to ACCEPT.
- ACCEPT with finish=1 and in_valid=0 -> DONE. If finish and in_valid are both high, the transfer wins and finish is ignored; the requester holds finish.
- DONE: done = 1 for one cycle, then IDLE. count and error hold until the next start.
- start outside IDLE is ignored.
- Encodings, listed MSB to LSB:
  - load: imm[11:0], rs1, funct3, rd, 0000011
  - store: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011
  - R-type: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011
  - I-type, funct3 != 001/101: imm[11:0], rs1, funct3, rd, 0010011
  - I-type shift (funct3 = 001/101): 0, funct7b5, 00000, imm[4:0], rs1, funct3, rd, 0010011
  - branch: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, busy 0, done 0, error 0.
- Latency: handshake in cycle N gives imem_we/addr/wdata in cycle N+1. Throughput is one word per 2 cycles.
- in_ready is 0 in IDLE, WRITE and DONE, and in ACCEPT when full.
- imem_addr and imem_wdata are stable for the whole imem_we cycle.
- Wrap-around: the address wraps after 2^ADDR_W-1, but the full check blocks a 2^ADDR_W+1-th write.
- Reset asserted mid-session (including during WRITE) clears everything immediately; a pending write is dropped.
- start and finish are level-sampled, so a one-cycle pulse suffices.

## Test plan
- start; I-type rd=1, rs1=0, funct3=0, imm=5 -> next cycle imem_we=1, addr=0, wdata=0x00500093, count=1.
- Load rd=2, rs1=1, funct3=2, imm=8, then store rs1=1, rs2=2, funct3=2, imm=12 -> wdata 0x0080A103 at addr 0, then 0x0020A623 at addr 1.
- R-type rd=3, rs1=1, rs2=2, funct3=0, funct7b5=1 -> 0x402081B3. Branch rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3.
- in_class=6, then branch with imm=3 -> both accepted with no imem_we; error=1; address and count unchanged.
- ADDR_W=2: write 4 words -> in_ready=0; a 5th in_valid sets error; finish -> done pulse, count=4, busy=0.
- rst asserted in WRITE -> no write completes; all outputs at reset values the same cycle.

Source files
------------

// File: rtl/instr_encode_loader.sv
// RV32I field-level instruction encoder that streams packed words into
// consecutive instruction-memory locations, one load session at a time.
module instr_encode_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] C_LOAD   = 3'd0;
  localparam logic [2:0] C_STORE  = 3'd1;
  localparam logic [2:0] C_RTYPE  = 3'd2;
  localparam logic [2:0] C_ITYPE  = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              error_reg, error_next;

  logic              full;
  logic              class_legal;
  logic              misaligned;
  logic              is_shift;
  logic [31:0]       enc_word;

  assign full        = (count_reg == CAPACITY);
  assign class_legal = (in_class <= C_BRANCH);
  // Branch targets are halfword multiples; bit 0 has no slot in the word.
  assign misaligned  = (in_class == C_BRANCH) && in_imm[0];
  // funct3 001/101 are slli/srli/srai: the immediate is a 5-bit shamt.
  assign is_shift    = (in_funct3[1:0] == 2'b01);

  always_comb begin
    enc_word = 32'h0000_0000;
    case (in_class)
      C_LOAD:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      C_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      C_RTYPE:
        enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
      C_ITYPE: begin
        if (is_shift) begin
          enc_word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd,
                      OP_ITYPE};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
        end
      end
      C_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], OP_BRANCH};
      default:
        enc_word = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    count_next = count_reg;
    error_next = error_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ACCEPT;
          addr_next  = BASE;
          count_next = '0;
          error_next = 1'b0;
        end
      end
      S_ACCEPT: begin
        // A pending transfer takes priority over finish.
        if (in_valid) begin
          if (full || !class_legal || misaligned) begin
            error_next = 1'b1;
          end else begin
            wdata_next = enc_word;
            state_next = S_WRITE;
          end
        end else if (finish) begin
          state_next = S_DONE;
        end
      end
      S_WRITE: begin
        addr_next  = addr_reg + 1'b1;
        count_next = count_reg + 1'b1;
        state_next = S_ACCEPT;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= BASE;
      wdata_reg <= 32'h0000_0000;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  assign in_ready   = (state_reg == S_ACCEPT) && !full;
  assign imem_we    = (state_reg == S_WRITE);
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign count      = count_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign error      = error_reg;

endmodule
